// File: rtl/tdm_demux.sv
// TDM lane demultiplexer: turns a serial stream of lane samples, framed by a
// start-of-frame marker on lane 0, into one wide word holding a whole frame.
//
// Handshake: a beat is accepted on every rising clk edge where in_valid=1.
// There is no backpressure. in_sof and in_data are only meaningful with
// in_valid=1. out_valid is a one-cycle pulse that marks the cycle in which
// out_data first shows a new frame. out_data then holds that frame until the
// next pulse.
module tdm_demux #(
  parameter int WIDTH   = 8,
  parameter int N_LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [WIDTH-1:0]           in_data,
  output logic [N_LANES*WIDTH-1:0]   out_data,
  output logic                       out_valid,
  output logic                       sync_err,
  output logic                       busy,
  output logic                       o_dbg_state
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [N_LANES*WIDTH-1:0]    r_shadow;
  logic [N_LANES*WIDTH-1:0]    r_out_data;
  logic                        r_out_valid;
  logic                        r_sync_err;

  // The newest frame is the lower lanes already in the shadow register plus the
  // beat being accepted now as the top lane. Because every frame rewrites lanes
  // 0..N_LANES-2 before it can complete, lanes left over from an aborted frame
  // can never reach out_data. The shadow therefore never needs clearing.
  logic [N_LANES*WIDTH-1:0]    w_frame;
  generate
    if (N_LANES > 1) begin : g_frame
      assign w_frame = {in_data, r_shadow[(N_LANES-1)*WIDTH-1:0]};
    end else begin : g_frame_one
      assign w_frame = in_data;
    end
  endgenerate

  // Frame-assembly FSM. Reset wins over a beat on the same edge.
  // The output pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (in_valid) begin
        case (r_state)
          S_IDLE: begin
            // Beats without a start marker are dropped until the stream syncs.
            if (in_sof) begin
              r_shadow[WIDTH-1:0] <= in_data;
              r_idx               <= IDX_W'(1);
              r_state             <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            if (in_sof) begin
              // A premature start marker abandons the partial frame and
              // restarts at lane 0. The FSM stays in COLLECT.
              r_sync_err          <= 1'b1;
              r_shadow[WIDTH-1:0] <= in_data;
              r_idx               <= IDX_W'(1);
            end else if (r_idx == LAST_IDX) begin
              r_out_data  <= w_frame;
              r_out_valid <= 1'b1;
              r_idx       <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_shadow[r_idx*WIDTH +: WIDTH] <= in_data;
              r_idx                          <= r_idx + IDX_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign sync_err    = r_sync_err;
  assign busy        = (r_state == S_COLLECT);
  assign o_dbg_state = r_state;

endmodule
